cdb_arbiter: RTL
================

Name: cdb_arbiter

Overview:
Shares the two common-data-bus (CDB) broadcast ports between three result producers: ALU1, ALU2 and the LSB load path. Each producer pushes results into a small per-source queue. A round-robin scheduler grants up to two queue heads per cycle onto CDB port 1 and CDB port 2. The CDB ports drive the done/value/tag wake-up inputs of the reservation station, LSB and ROB, so producers never broadcast directly. A mispredict clear flushes all queued results.

Parameters:
ROB_WIDTH, 4, width of ROB tag carried with each result
QUEUE_WIDTH, 1, log2 of per-source queue depth
QUEUE_SIZE, 2**QUEUE_WIDTH, entries per source queue

Ports:
clk_in  in  1  system clock
rst_in  in  1  synchronous active-high reset
rdy_in  in  1  global enable; when low, all state holds
clear_signal  in  1  1 for prediction error; flush all queues
valid_alu_1 / valid_alu_2 / valid_lsb  in  1 each  producer has a result this cycle
value_alu_1 / value_alu_2 / value_lsb  in  32 each  result data
tag_alu_1 / tag_alu_2 / tag_lsb  in  ROB_WIDTH each  destination ROB tag
ready_alu_1 / ready_alu_2 / ready_lsb  out  1 each  source queue not full
done_cdb_1, done_cdb_2  out  1 each  CDB port carries a valid result
value_cdb_1, value_cdb_2  out  32 each  broadcast data
tag_cdb_1, tag_cdb_2  out  ROB_WIDTH each  broadcast tag

Behaviour:
- Source indices: 0 = ALU1, 1 = ALU2, 2 = LSB.
- Per-source FIFO has head pointer, tail pointer and count (0..QUEUE_SIZE).
- ready_x = (count_x < QUEUE_SIZE), a function of registered count only. A pop in the same cycle does not make ready_x high; there is no combinational ready/pop path.
- Push: at the posedge, if rdy_in & ~clear_signal & valid_x & ready_x, write {value, tag} at the tail. valid_x while ready_x = 0 is a producer protocol error; the result is dropped.
- Scheduling (combinational, from registered state): scan sources in order rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3).
  - The first non-empty source drives CDB port 1; the second drives CDB port 2.
  - Each source receives at most one grant per cycle.
  - Port 2 is never used while port 1 is idle.
- CDB outputs come combinationally from the granted queue heads. done_cdb_n = 1 iff port n is granted. value/tag are 0 when done is 0.
- Outputs are not gated by rdy_in. Consumers sample them only when rdy_in is high, and the arbiter pops only then.
- Pop: at the posedge, if rdy_in & ~clear_signal, each granted queue advances its head.
- Simultaneous push and pop on the same queue: count unchanged; both pointers advance.
- Latency: a result pushed at edge N appears on the CDB at the earliest in the cycle after edge N. There is no same-cycle bypass.
- rr_ptr update: after a cycle with at least one grant, rr_ptr <= (index of last granted source + 1) mod 3. Otherwise it holds.
- clear_signal & rdy_in: at the posedge, all counts and pointers go to 0 and rr_ptr goes to 0. Same-cycle pushes are discarded and no pops occur. CDB outputs may still show heads during that cycle, but consumers ignore them under clear.
- rdy_in low: no push, no pop, no pointer change. Outputs stay stable.
- Reset (rst_in = 1, priority over everything): counts, head/tail pointers and rr_ptr go to 0. After reset: done_cdb_1/2 = 0, value/tag = 0, all ready_x = 1. Reset mid-operation discards queued results.
- Pointer wrap: head/tail are QUEUE_WIDTH bits and wrap naturally. Count is QUEUE_WIDTH+1 bits.

Decomposition:
- Shared package holds:
  - source index constants SRC_ALU1 = 0, SRC_ALU2 = 1, SRC_LSB = 2, NUM_SRC = 3
  - a cdb_entry typedef {value[31:0], tag[ROB_WIDTH-1:0]}
  - ROB_WIDTH default
- One natural sub-module: result_fifo. It is a parameterised synchronous FIFO with push/pop/flush, count, and head data out, instantiated three times.
- The scheduler and rr_ptr stay in cdb_arbiter.

Test Plan:
- Reset, then a single push valid_alu_1 = 1, value = 0x0000_00AA, tag = 3 -> next cycle done_cdb_1 = 1, value_cdb_1 = 0xAA, tag_cdb_1 = 3, done_cdb_2 = 0. The cycle after, both done = 0.
- All three valid in one cycle (tags 1, 2, 5), rr_ptr = 0 -> next cycle port1 = tag 1, port2 = tag 2. The following cycle port1 = tag 5 (LSB), and rr_ptr ends at 0.
- Round-robin fairness: keep all three queues non-empty for 6 cycles -> grant pairs (0,1), (2,0), (1,2), (0,1), ... Each source is granted 4 times in 6 cycles.
- Backpressure: push 2 ALU2 results while ALU1 and LSB are busy with continuous traffic -> ready_alu_2 = 0 once count = 2. A third ALU2 push is not accepted. ready_alu_2 returns to 1 the cycle after its head pops.
- Clear: queues holding 2/1/2 entries, assert clear_signal together with new pushes -> next cycle all done = 0, all ready = 1, and rr_ptr = 0.
- rdy_in = 0 for 3 cycles with pending entries -> outputs are identical across the three cycles with no pops. When rdy_in returns, the same entries are granted first.

Source files
------------

// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared constants and types for the CDB arbiter
// Purpose: source indices, default ROB tag width, result entry type and
//          the mod-3 source wrap helper used by the round-robin scan.
// Ports:   none (package).
package cdb_arbiter_pkg;

    localparam int ROB_WIDTH_DEFAULT = 4;

    localparam int         NUM_SRC  = 3;
    localparam logic [1:0] SRC_ALU1 = 2'd0;
    localparam logic [1:0] SRC_ALU2 = 2'd1;
    localparam logic [1:0] SRC_LSB  = 2'd2;

    typedef struct packed {
        logic [31:0]                  value;
        logic [ROB_WIDTH_DEFAULT-1:0] tag;
    } cdb_entry;

    // Folds a source index in 0..5 back into 0..2.
    function automatic logic [1:0] src_wrap(input logic [2:0] s);
        return (s >= 3'd3) ? 2'(s - 3'd3) : s[1:0];
    endfunction

endpackage

// File: rtl/cdb_arbiter_fifo.sv
// rtl/cdb_arbiter_fifo.sv - per-source result queue (result_fifo)
// Purpose: synchronous FIFO with push, pop and flush; exposes head data,
//          occupancy count and empty flag.
// Ports:   clk_in, rst_in (sync active-high), flush_in, push_in,
//          push_data_in, pop_in, head_data_out, count_out, empty_out.
module result_fifo #(
    parameter int DATA_W = 36,
    parameter int ADDR_W = 1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              push_in,
    input  logic [DATA_W-1:0] push_data_in,
    input  logic              pop_in,
    output logic [DATA_W-1:0] head_data_out,
    output logic [ADDR_W:0]   count_out,
    output logic              empty_out
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [ADDR_W-1:0] head_q, head_d;
    logic [ADDR_W-1:0] tail_q, tail_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic              full;
    logic              do_push;
    logic              do_pop;

    assign full          = (count_q == (ADDR_W+1)'(DEPTH));
    assign empty_out     = (count_q == '0);
    assign count_out     = count_q;
    assign head_data_out = mem_q[head_q];

    always_comb begin
        // A push into a full queue is dropped; flush wins over both.
        do_push = push_in & ~full & ~flush_in;
        do_pop  = pop_in & ~empty_out & ~flush_in;
        head_d  = head_q + ADDR_W'(do_pop);
        tail_d  = tail_q + ADDR_W'(do_push);
        count_d = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
        if (flush_in) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem_q[tail_q] <= push_data_in;
        end
    end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - shares two CDB broadcast ports among ALU1, ALU2, LSB
// Purpose: queues results per producer and grants up to two queue heads per
//          cycle onto CDB ports 1 and 2 in round-robin order.
// Ports:   clk_in, rst_in (sync active-high), rdy_in (global enable),
//          clear_signal (flush), valid/value/tag per producer in,
//          ready per producer out, done/value/tag per CDB port out.
module cdb_arbiter
    import cdb_arbiter_pkg::*;
#(
    parameter int ROB_WIDTH   = ROB_WIDTH_DEFAULT,
    parameter int QUEUE_WIDTH = 1,
    parameter int QUEUE_SIZE  = 2 ** QUEUE_WIDTH
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    input  logic                 rdy_in,
    input  logic                 clear_signal,
    input  logic                 valid_alu_1,
    input  logic [31:0]          value_alu_1,
    input  logic [ROB_WIDTH-1:0] tag_alu_1,
    input  logic                 valid_alu_2,
    input  logic [31:0]          value_alu_2,
    input  logic [ROB_WIDTH-1:0] tag_alu_2,
    input  logic                 valid_lsb,
    input  logic [31:0]          value_lsb,
    input  logic [ROB_WIDTH-1:0] tag_lsb,
    output logic                 ready_alu_1,
    output logic                 ready_alu_2,
    output logic                 ready_lsb,
    output logic                 done_cdb_1,
    output logic [31:0]          value_cdb_1,
    output logic [ROB_WIDTH-1:0] tag_cdb_1,
    output logic                 done_cdb_2,
    output logic [31:0]          value_cdb_2,
    output logic [ROB_WIDTH-1:0] tag_cdb_2
);

    localparam int ENTRY_W = 32 + ROB_WIDTH;

    logic [NUM_SRC-1:0] src_valid;
    logic [ENTRY_W-1:0] src_entry  [NUM_SRC];
    logic [ENTRY_W-1:0] head_entry [NUM_SRC];
    logic [QUEUE_WIDTH:0] count    [NUM_SRC];
    logic [NUM_SRC-1:0] empty;
    logic [NUM_SRC-1:0] push;
    logic [NUM_SRC-1:0] pop;
    logic               advance;
    logic               flush;

    logic [1:0] rr_q, rr_d;
    logic       g1_valid, g2_valid;
    logic [1:0] g1_src, g2_src, scan_src, last_src;

    assign advance = rdy_in & ~clear_signal;
    assign flush   = rdy_in & clear_signal;

    assign src_valid           = {valid_lsb, valid_alu_2, valid_alu_1};
    assign src_entry[SRC_ALU1] = {value_alu_1, tag_alu_1};
    assign src_entry[SRC_ALU2] = {value_alu_2, tag_alu_2};
    assign src_entry[SRC_LSB]  = {value_lsb, tag_lsb};

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_fifo
        assign push[i] = advance & src_valid[i];

        result_fifo #(
            .DATA_W (ENTRY_W),
            .ADDR_W (QUEUE_WIDTH)
        ) u_fifo (
            .clk_in        (clk_in),
            .rst_in        (rst_in),
            .flush_in      (flush),
            .push_in       (push[i]),
            .push_data_in  (src_entry[i]),
            .pop_in        (pop[i]),
            .head_data_out (head_entry[i]),
            .count_out     (count[i]),
            .empty_out     (empty[i])
        );
    end

    // Ready looks only at registered occupancy; a same-cycle pop never
    // reopens a full queue.
    assign ready_alu_1 = count[SRC_ALU1] < (QUEUE_WIDTH+1)'(QUEUE_SIZE);
    assign ready_alu_2 = count[SRC_ALU2] < (QUEUE_WIDTH+1)'(QUEUE_SIZE);
    assign ready_lsb   = count[SRC_LSB]  < (QUEUE_WIDTH+1)'(QUEUE_SIZE);

    // Scan from rr_q: first non-empty source takes port 1, second port 2.
    always_comb begin
        g1_valid = 1'b0;
        g2_valid = 1'b0;
        g1_src   = SRC_ALU1;
        g2_src   = SRC_ALU1;
        scan_src = SRC_ALU1;
        for (int k = 0; k < NUM_SRC; k++) begin
            scan_src = src_wrap({1'b0, rr_q} + 3'(k));
            if (!empty[scan_src]) begin
                if (!g1_valid) begin
                    g1_valid = 1'b1;
                    g1_src   = scan_src;
                end else if (!g2_valid) begin
                    g2_valid = 1'b1;
                    g2_src   = scan_src;
                end
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            pop[i] = advance & ((g1_valid & (g1_src == 2'(i))) |
                                (g2_valid & (g2_src == 2'(i))));
        end
    end

    always_comb begin
        last_src = g2_valid ? g2_src : g1_src;
        rr_d     = rr_q;
        if (flush) begin
            rr_d = 2'd0;
        end else if (advance & g1_valid) begin
            rr_d = src_wrap({1'b0, last_src} + 3'd1);
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rr_q <= 2'd0;
        end else begin
            rr_q <= rr_d;
        end
    end

    always_comb begin
        done_cdb_1  = g1_valid;
        done_cdb_2  = g2_valid;
        value_cdb_1 = '0;
        tag_cdb_1   = '0;
        value_cdb_2 = '0;
        tag_cdb_2   = '0;
        if (g1_valid) begin
            value_cdb_1 = head_entry[g1_src][ENTRY_W-1:ROB_WIDTH];
            tag_cdb_1   = head_entry[g1_src][ROB_WIDTH-1:0];
        end
        if (g2_valid) begin
            value_cdb_2 = head_entry[g2_src][ENTRY_W-1:ROB_WIDTH];
            tag_cdb_2   = head_entry[g2_src][ROB_WIDTH-1:0];
        end
    end

endmodule
